// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step controller for the 24-bit CPU core.
// Produces a registered clock enable (CpuEn) and counts enabled cycles up to
// a limit sampled at Start. Supports halt, single-step and resume.
// Optional breakpoint compare is compiled in when RUN_BREAKPOINT_EN is defined.
module cpu_run_ctrl #(
    parameter int CNT_WIDTH      = 24,
    parameter int DEFAULT_CYCLES = 30
`ifdef RUN_BREAKPOINT_EN
    ,
    parameter int PC_WIDTH       = 24
`endif
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Step,
    input  logic                 Halt,
    input  logic [CNT_WIDTH-1:0] CycleLimit,
    output logic                 CpuEn,
    output logic                 Busy,
    output logic                 Paused,
    output logic                 Done,
    output logic [CNT_WIDTH-1:0] CycleCount
`ifdef RUN_BREAKPOINT_EN
    ,
    input  logic [PC_WIDTH-1:0]  PcIn,
    input  logic [PC_WIDTH-1:0]  BreakAddr,
    output logic                 BreakHit
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DEF_LIMIT = CNT_WIDTH'(DEFAULT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic                 cpu_en_q, cpu_en_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] limit_q, limit_d;
    logic [CNT_WIDTH-1:0] count_inc;
    logic [CNT_WIDTH-1:0] fresh_limit;
    logic                 go_start;
    logic                 go_step;
    logic                 bp_fire;
`ifdef RUN_BREAKPOINT_EN
    logic                 break_hit_q, break_hit_d;
    logic                 skip_cmp_q, skip_cmp_d;
`endif

    // Next-state logic: Halt masks Start, Start masks Step; a run that reaches
    // its limit ends in DONE even if Halt or a breakpoint arrives that cycle.
    always_comb begin
        state_d     = state_q;
        cpu_en_d    = cpu_en_q;
        count_d     = count_q;
        limit_d     = limit_q;
        count_inc   = count_q + ONE;
        fresh_limit = (CycleLimit == '0) ? DEF_LIMIT : CycleLimit;
        go_start    = !Halt && Start;
        go_step     = !Halt && !Start && Step;
`ifdef RUN_BREAKPOINT_EN
        break_hit_d = break_hit_q;
        skip_cmp_d  = skip_cmp_q;
        bp_fire     = cpu_en_q && !skip_cmp_q && (PcIn == BreakAddr);
`else
        bp_fire     = 1'b0;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (go_start || go_step) begin
                    limit_d  = fresh_limit;
                    count_d  = '0;
                    cpu_en_d = 1'b1;
                    state_d  = go_start ? S_RUN : S_STEP;
`ifdef RUN_BREAKPOINT_EN
                    break_hit_d = 1'b0;
                    skip_cmp_d  = 1'b0;
`endif
                end
            end
            S_PAUSE: begin
                if (go_start || go_step) begin
                    cpu_en_d = 1'b1;
                    state_d  = go_start ? S_RUN : S_STEP;
`ifdef RUN_BREAKPOINT_EN
                    break_hit_d = 1'b0;
                    skip_cmp_d  = go_start;
`endif
                end
            end
            S_RUN: begin
                if (cpu_en_q) begin
                    count_d = count_inc;
`ifdef RUN_BREAKPOINT_EN
                    skip_cmp_d = 1'b0;
`endif
                    if (count_inc == limit_q) begin
                        state_d  = S_DONE;
                        cpu_en_d = 1'b0;
                    end else if (Halt) begin
                        state_d  = S_PAUSE;
                        cpu_en_d = 1'b0;
                    end else if (bp_fire) begin
                        state_d  = S_PAUSE;
                        cpu_en_d = 1'b0;
`ifdef RUN_BREAKPOINT_EN
                        break_hit_d = 1'b1;
`endif
                    end
                end
            end
            S_STEP: begin
                count_d  = count_inc;
                cpu_en_d = 1'b0;
                state_d  = (count_inc == limit_q) ? S_DONE : S_PAUSE;
            end
            default: begin
                state_d  = S_IDLE;
                cpu_en_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops CpuEn immediately.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            cpu_en_q <= 1'b0;
            count_q  <= '0;
            limit_q  <= DEF_LIMIT;
`ifdef RUN_BREAKPOINT_EN
            break_hit_q <= 1'b0;
            skip_cmp_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
            count_q  <= count_d;
            limit_q  <= limit_d;
`ifdef RUN_BREAKPOINT_EN
            break_hit_q <= break_hit_d;
            skip_cmp_q  <= skip_cmp_d;
`endif
        end
    end

    assign CpuEn      = cpu_en_q;
    assign Busy       = (state_q == S_RUN) || (state_q == S_STEP);
    assign Paused     = (state_q == S_PAUSE);
    assign Done       = (state_q == S_DONE);
    assign CycleCount = count_q;
`ifdef RUN_BREAKPOINT_EN
    assign BreakHit   = break_hit_q;
`endif

endmodule
